alu_16_sequencer: RTL and testbench

// - Initiator side of the alu_8 interface: takes one 16-bit ALU request, issues byte-wide passes on
//   alu_a/alu_b/alu_opcode, captures alu_out each pass, returns a 16-bit result plus carry/zero flags.
// - Implements Z80 16-bit ADD/SUB/AND/OR/XOR on the 8-bit datapath; alu_8 has no carry-in, so carry
//   is derived from byte compares and applied in an extra fix-up pass. alu_8 instantiated by parent.

---
 rtl/z80_alu_pkg.sv | 32 +++
 rtl/alu_16_sequencer_if.sv | 29 ++
 rtl/alu_8.sv | 29 ++
 rtl/alu_16_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_16_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/z80_alu_pkg.sv
// Shared definitions for the Z80-style ALU blocks.
// Holds the alu_8 opcode encodings, the 16-bit sequencer state type
// and small opcode classification helpers used by the sequencer.
package z80_alu_pkg;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_SUB = 5'd1;
  localparam logic [4:0] ALU_OP_AND = 5'd2;
  localparam logic [4:0] ALU_OP_OR  = 5'd3;
  localparam logic [4:0] ALU_OP_XOR = 5'd4;
  localparam logic [4:0] ALU_OP_INC = 5'd5;
  localparam logic [4:0] ALU_OP_DEC = 5'd6;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    FIX,
    DONE
  } alu16_state_t;

  // Opcodes the 16-bit sequencer knows how to split into byte passes.
  function automatic logic op_supported(input logic [4:0] op);
    return (op <= ALU_OP_XOR);
  endfunction

  // Add/sub need the carry fix-up pass; logical ops do not.
  function automatic logic op_arith(input logic [4:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_16_sequencer_if.sv
// Request/response handshake bundle for alu_16_sequencer.
//   req_valid/req_ready : request handshake, req_op/req_a/req_b payload
//   rsp_valid/rsp_ready : response handshake, rsp_result/carry/zero/err payload
// master: request issuer / response consumer. slave: the sequencer.
interface alu_16_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_8.sv
// 8-bit combinational ALU without carry-in or carry-out.
// Ports:
//   a_i, b_i  : 8-bit operands
//   opcode_i  : 5-bit operation select (z80_alu_pkg encodings)
//   y_o       : 8-bit result, unknown opcodes give 0
module alu_8
  import z80_alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [4:0] opcode_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'h00;
    case (opcode_i)
      ALU_OP_ADD: y_o = a_i + b_i;
      ALU_OP_SUB: y_o = a_i - b_i;
      ALU_OP_AND: y_o = a_i & b_i;
      ALU_OP_OR:  y_o = a_i | b_i;
      ALU_OP_XOR: y_o = a_i ^ b_i;
      ALU_OP_INC: y_o = a_i + 8'd1;
      ALU_OP_DEC: y_o = a_i - 8'd1;
      default:    y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_16_sequencer.sv
// 16-bit ADD/SUB/AND/OR/XOR built from byte-wide passes over an external alu_8.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   bus (slave)           : request in (op, a, b), response out (result, carry, zero, err)
//   alu_a/alu_b/alu_opcode: operands and opcode driven to alu_8 (registered)
//   alu_out               : combinational result returned by alu_8
// Since alu_8 has no carry-in, carries are derived from unsigned byte compares
// and the low-byte carry/borrow is folded into the high byte by a FIX pass.
module alu_16_sequencer
  import z80_alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_16_sequencer_if.slave    bus,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [4:0]           alu_opcode,
  input  logic [7:0]           alu_out
);

  alu16_state_t state_q;

  logic [4:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic        c_lo_q;
  logic        c_hi_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_result_q;
  logic        rsp_carry_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic [4:0]  alu_op_q;

  logic        accept;
  logic        is_add;
  logic        is_sub;
  logic        c_lo_d;
  logic        c_hi_d;
  logic        c_fix_d;
  logic [15:0] result_d;

  assign accept = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign is_add = (op_q == ALU_OP_ADD);
  assign is_sub = (op_q == ALU_OP_SUB);

  // Add carries out iff the byte sum wrapped below operand a; sub borrows iff a < b.
  assign c_lo_d = is_add ? (alu_out < a_q[7:0])  : is_sub ? (a_q[7:0]  < b_q[7:0])  : 1'b0;
  assign c_hi_d = is_add ? (alu_out < a_q[15:8]) : is_sub ? (a_q[15:8] < b_q[15:8]) : 1'b0;

  // Folding c_lo into the high byte can itself carry (hi was FF -> 00) or
  // borrow (hi was 00 -> FF); hi_q still holds the pre-fix byte here.
  assign c_fix_d = c_lo_q & (is_add ? (alu_out == 8'h00) : (hi_q == 8'h00));

  // Whatever alu_out holds in HI/FIX is the final high byte.
  assign result_d = {alu_out, lo_q};

  // Operand and byte-pass capture; meaningful only while a request is in flight.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_q <= bus.req_op;
          a_q  <= bus.req_a;
          b_q  <= bus.req_b;
        end
      end
      LO: begin
        lo_q   <= alu_out;
        c_lo_q <= c_lo_d;
      end
      HI: begin
        hi_q   <= alu_out;
        c_hi_q <= c_hi_d;
      end
      FIX: begin
        hi_q <= alu_out;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake, response and ALU-drive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_op_q     <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (op_supported(bus.req_op)) begin
              state_q  <= LO;
              alu_a_q  <= bus.req_a[7:0];
              alu_b_q  <= bus.req_b[7:0];
              alu_op_q <= bus.req_op;
            end else begin
              state_q      <= DONE;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= 16'h0000;
              rsp_carry_q  <= 1'b0;
              rsp_zero_q   <= 1'b1;
              rsp_err_q    <= 1'b1;
            end
          end
        end
        LO: begin
          state_q <= HI;
          alu_a_q <= a_q[15:8];
          alu_b_q <= b_q[15:8];
        end
        HI: begin
          if (op_arith(op_q)) begin
            state_q <= FIX;
            alu_a_q <= alu_out;
            alu_b_q <= {7'b0, c_lo_q};
          end else begin
            state_q      <= DONE;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_op_q     <= 5'd0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= result_d;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= (result_d == 16'h0000);
            rsp_err_q    <= 1'b0;
          end
        end
        FIX: begin
          state_q      <= DONE;
          alu_a_q      <= 8'h00;
          alu_b_q      <= 8'h00;
          alu_op_q     <= 5'd0;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= result_d;
          rsp_carry_q  <= c_hi_q | c_fix_d;
          rsp_zero_q   <= (result_d == 16'h0000);
          rsp_err_q    <= 1'b0;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_opcode     = alu_op_q;

endmodule

// File: tb/tb_alu_16_sequencer.sv
// Directed bench for alu_16_sequencer with an alu_8 wired to its ALU port.
module tb_alu_16_sequencer;
  import z80_alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_opcode;
  logic [7:0] alu_out;

  int n_chk;
  int n_err;

  alu_16_sequencer_if bus();

  alu_16_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out)
  );

  alu_8 u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .opcode_i (alu_opcode),
    .y_o      (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves lat at the number of posedges after the accept edge before rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_req(input string tag, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_c, input logic exp_z, input logic exp_e);
    int lat;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    chk({tag, "_lat"},    lat,            exp_lat);
    chk({tag, "_result"}, bus.rsp_result, exp_res);
    chk({tag, "_carry"},  bus.rsp_carry,  exp_c);
    chk({tag, "_zero"},   bus.rsp_zero,   exp_z);
    chk({tag, "_err"},    bus.rsp_err,    exp_e);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready_back"}, {bus.req_ready, bus.rsp_valid}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic seen;
    n_chk = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 5'd0;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready,  1'b1);
    chk("rst_rsp_valid", bus.rsp_valid,  1'b0);
    chk("rst_result",    bus.rsp_result, 16'h0000);
    chk("rst_carry",     bus.rsp_carry,  1'b0);
    chk("rst_zero",      bus.rsp_zero,   1'b0);
    chk("rst_err",       bus.rsp_err,    1'b0);
    chk("rst_alu_a",     alu_a,          8'h00);
    chk("rst_alu_b",     alu_b,          8'h00);
    chk("rst_alu_op",    alu_opcode,     5'd0);
    rst = 1'b0;

    run_req("add_00ff", ALU_OP_ADD, 16'h00FF, 16'h0001, 3, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_req("add_ffff", ALU_OP_ADD, 16'hFFFF, 16'h0001, 3, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_req("sub_0100", ALU_OP_SUB, 16'h0100, 16'h0001, 3, 16'h00FF, 1'b0, 1'b0, 1'b0);
    run_req("sub_0000", ALU_OP_SUB, 16'h0000, 16'h0001, 3, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_req("xor",      ALU_OP_XOR, 16'hF0F0, 16'hFFFF, 2, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    run_req("and",      ALU_OP_AND, 16'h1234, 16'h0F0F, 2, 16'h0204, 1'b0, 1'b0, 1'b0);
    run_req("or",       ALU_OP_OR,  16'h1200, 16'h0034, 2, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_req("bad_op",   5'd6,       16'h1234, 16'h5678, 0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Response back-pressure with a second request waiting behind it.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_op    = ALU_OP_ADD;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h1111;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_op = ALU_OP_OR;
    bus.req_a  = 16'h00F0;
    bus.req_b  = 16'h0F00;
    wait_rsp(lat);
    chk("stall_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_result",    bus.rsp_result, 16'h2345);
      chk("stall_valid",     {bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 4'b1000);
      chk("stall_req_ready", bus.req_ready,  1'b0);
      @(negedge clk);
    end
    chk("stall_alu_idle", {alu_a, alu_b, alu_opcode}, 21'h0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_hs_ready", {bus.req_ready, bus.rsp_valid}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("next_accepted", bus.req_ready, 1'b0);
    wait_rsp(lat);
    chk("next_lat",    lat,            2);
    chk("next_result", bus.rsp_result, 16'h0FF0);
    @(posedge clk);
    @(negedge clk);

    // Reset while the high-byte pass is on the ALU.
    bus.req_op    = ALU_OP_ADD;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h00FF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lo_alu_drive", {alu_a, alu_b, alu_opcode}, {8'h34, 8'hFF, ALU_OP_ADD});
    @(negedge clk);
    chk("hi_alu_drive", {alu_a, alu_b, alu_opcode}, {8'h12, 8'h00, ALU_OP_ADD});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {bus.req_ready, bus.rsp_valid}, 2'b10);
    chk("midrst_alu",   {alu_a, alu_b, alu_opcode}, 21'h0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
